gfx_fetch_scheduler: RTL and testbench
======================================

# gfx_fetch_scheduler

Per-scanline scheduler and arbiter sharing one graphics-ROM/SDRAM read port between four layer fetchers (0 = text, 1 = foreground, 2 = background, 3 = sprites). Sits between the video timing generator, the layer fetch engines and the SDRAM controller. Requesters are served round-robin, but the sprite engine has absolute priority during horizontal blank. The block also derives the line-buffer select and the line-start and frame-start strobes from the timing signals.

## Interface
- AW, 24, memory word address width.
- DW, 32, memory data width.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clk_pix  in  1  pixel-clock enable, one clk cycle wide.
- hbl  in  1  horizontal blank from the timing generator.
- vbl  in  1  vertical blank from the timing generator.
- req  in  4  per-requester read request, level; held until that requester's ack.
- req_addr  in  4*AW  request addresses; requester i uses bits [i*AW +: AW]; stable while req[i] is high.
- ack  out  4  one-cycle pulse to the served requester; rd_data is valid in the same cycle.
- rd_data  out  DW  registered read data.
- mem_req  out  1  memory request, level, held until mem_ack.
- mem_addr  out  AW  memory address, stable while mem_req is high.
- mem_ack  in  1  memory completion pulse; mem_data is valid in the same cycle.
- mem_data  in  DW  memory read data.
- line_sel  out  1  line-buffer bank select; toggles once per line.
- line_start  out  1  one-cycle pulse at the start of horizontal blank.
- frame_start  out  1  one-cycle pulse at the start of vertical blank.
- spr_overrun  out  1  sticky flag: sprite fetch did not finish within horizontal blank.

## Operation
- Arbiter FSM has three states: IDLE, BUSY and DONE.
- IDLE → BUSY: taken when any req bit is high.
  - Winner = 3 if hbl && req[3].
  - Otherwise the first set bit searching upward (mod 4) from rr_ptr.
  - On the grant, latch the winner index and its address; set rr_ptr = winner+1 mod 4.
- BUSY: mem_req = 1 and mem_addr = the latched address.
  - On mem_ack, capture mem_data into rd_data and go to DONE.
- DONE: ack[winner] = 1 for this cycle, then go to IDLE.
- A requester may keep req high after its ack to request again. In IDLE its address is sampled fresh.
- mem_ack is ignored in IDLE and in DONE. Transactions are never aborted by timing events; only reset ends one.
- Edge detection uses hbl and vbl registered on clk_pix cycles. Rising edges are evaluated only when clk_pix = 1.
  - hbl rising: line_start pulses and line_sel toggles.
  - vbl rising: frame_start pulses and spr_overrun clears.
  - hbl falling with req[3] = 1 (sampled in that clk_pix cycle): set spr_overrun.
  - If overrun-set and frame_start occur in the same cycle, set wins.
- Reset values:
  - All outputs are 0: ack, rd_data, mem_req, mem_addr, line_sel, line_start, frame_start, spr_overrun.
  - State = IDLE, rr_ptr = 0, hbl/vbl history = 0.
- Reset mid-transaction: mem_req drops in the cycle after reset is asserted. A late mem_ack after reset is ignored.

## Timing
- req sampled in IDLE at cycle N → mem_req high at N+1.
- mem_ack at cycle M → ack and rd_data at M+1 (DONE); IDLE at M+2.
- Minimum spacing between grants is 3 cycles plus memory latency.
- mem_ack in the same cycle mem_req first rises is legal and completes the transaction.
- line_start and frame_start appear 1 clk after the clk_pix cycle in which the edge is seen. line_sel changes in that same cycle.

## Structure
- Shared package contains:
  - The requester index constants: REQ_TXT = 0, REQ_FG = 1, REQ_BG = 2, REQ_SPR = 3.
  - The FSM state encoding.
- One sub-module is natural: gfx_rr_arbiter.
  - Combinational 4-way round-robin pick with a priority override input.
  - Outputs the winner index and a valid flag.

## Test plan
- Reset: assert reset for 2 cycles while req = 4'b1111 → mem_req = 0, ack = 0, line_sel = 0 throughout. First grant after release goes to requester 0.
- Round-robin: req = 4'b0111 held high, hbl = 0, mem_ack 2 cycles after each mem_req → grant order 0, 1, 2, 0; each ack carries that request's mem_data (for example 32'hA5A50001 for the first).
- Sprite priority: hbl = 1, rr_ptr = 1, req = 4'b1010 → requester 3 granted first and rr_ptr becomes 0. With hbl = 0 the same request pattern grants 1 first.
- Line strobes: drive a 387-pixel line with hbl rising at pixel 351 → exactly one line_start per line, line_sel alternates 0/1/0. frame_start pulses once per 262 lines at vbl rise.
- Overrun: hold req[3] high across an hbl falling edge (never acked) → spr_overrun = 1, held until the next vbl rising edge, then 0.
- Reset mid-BUSY: assert reset while mem_req = 1, and deliver mem_ack 1 cycle after reset is released → no ack pulse and rd_data stays 0.

Source files
------------

// File: rtl/gfx_fetch_scheduler_pkg.sv
// Shared definitions for the graphics fetch scheduler.
//   - Requester index constants (which bit of req/ack belongs to which layer).
//   - Arbiter FSM state encoding.
package gfx_fetch_scheduler_pkg;

  localparam int NUM_REQ = 4;

  localparam int REQ_TXT = 0;
  localparam int REQ_FG  = 1;
  localparam int REQ_BG  = 2;
  localparam int REQ_SPR = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/gfx_fetch_scheduler_rr_arbiter.sv
// gfx_rr_arbiter: combinational 4-way round-robin pick with a priority override.
//   req_i   : request vector, one bit per layer fetcher
//   ptr_i   : round-robin pointer, the search starts at this index
//   prio_i  : when high and the sprite requester is asking, sprites win outright
//   win_o   : winning requester index
//   valid_o : at least one request is pending
module gfx_rr_arbiter
  import gfx_fetch_scheduler_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic       prio_i,
  output logic [1:0] win_o,
  output logic       valid_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    win_o   = '0;
    valid_o = |req_i;
    idx     = '0;
    found   = 1'b0;
    if (prio_i && req_i[REQ_SPR]) begin
      win_o = 2'(REQ_SPR);
    end else begin
      // Search upward from the pointer, wrapping naturally in 2 bits.
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = ptr_i + 2'(k);
        if (!found && req_i[idx]) begin
          win_o = idx;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gfx_fetch_scheduler.sv
// gfx_fetch_scheduler: shares one graphics-ROM/SDRAM read port between the
// text, foreground, background and sprite fetchers, and derives per-line and
// per-frame strobes from the video timing.
//   clk, reset           : system clock, synchronous active-high reset
//   clk_pix              : pixel-clock enable (one clk wide)
//   hbl, vbl             : horizontal / vertical blank
//   req, req_addr        : per-requester level request and address
//   ack, rd_data         : one-cycle ack to the served requester with its data
//   mem_req, mem_addr    : memory request (level) and address
//   mem_ack, mem_data    : memory completion pulse and read data
//   line_sel             : line-buffer bank select, toggles every line
//   line_start           : pulse at start of horizontal blank
//   frame_start          : pulse at start of vertical blank
//   spr_overrun          : sticky, sprite fetch still pending when hblank ended
module gfx_fetch_scheduler
  import gfx_fetch_scheduler_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_pix,
  input  logic              hbl,
  input  logic              vbl,
  input  logic [3:0]        req,
  input  logic [4*AW-1:0]   req_addr,
  output logic [3:0]        ack,
  output logic [DW-1:0]     rd_data,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_data,
  output logic              line_sel,
  output logic              line_start,
  output logic              frame_start,
  output logic              spr_overrun
);

  fetch_state_e  state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    win_q, win_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [1:0]    arb_win;
  logic          arb_valid;
  logic [AW-1:0] sel_addr;

  gfx_rr_arbiter u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .prio_i  (hbl),
    .win_o   (arb_win),
    .valid_o (arb_valid)
  );

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_win == 2'(k)) sel_addr = req_addr[k*AW +: AW];
    end
  end

  // Arbiter FSM: state and transaction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Arbiter FSM: next state
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_BUSY;
          win_d    = arb_win;
          addr_d   = sel_addr;
          rr_ptr_d = arb_win + 2'd1;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          rd_data_d = mem_data;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter FSM: outputs
  always_comb begin
    mem_req  = (state_q == ST_BUSY);
    mem_addr = addr_q;
    rd_data  = rd_data_q;
    ack      = '0;
    if (state_q == ST_DONE) ack[win_q] = 1'b1;
  end

  // Timing strobes: blank history only advances on pixel-enable cycles
  logic hbl_q, vbl_q;
  logic line_sel_q, line_start_q, frame_start_q, spr_overrun_q;
  logic hbl_rise, hbl_fall, vbl_rise;

  assign hbl_rise = clk_pix &  hbl & ~hbl_q;
  assign hbl_fall = clk_pix & ~hbl &  hbl_q;
  assign vbl_rise = clk_pix &  vbl & ~vbl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hbl_q         <= 1'b0;
      vbl_q         <= 1'b0;
      line_sel_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      spr_overrun_q <= 1'b0;
    end else begin
      if (clk_pix) begin
        hbl_q <= hbl;
        vbl_q <= vbl;
      end
      line_start_q  <= hbl_rise;
      frame_start_q <= vbl_rise;
      if (hbl_rise) line_sel_q <= ~line_sel_q;
      // A sprite request still pending when hblank ends is an overrun;
      // setting takes precedence over the frame-start clear.
      if (hbl_fall && req[REQ_SPR]) spr_overrun_q <= 1'b1;
      else if (vbl_rise)            spr_overrun_q <= 1'b0;
    end
  end

  assign line_sel    = line_sel_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign spr_overrun = spr_overrun_q;

endmodule

// File: tb/tb_gfx_fetch_scheduler.sv
// Directed self-checking bench for gfx_fetch_scheduler.
module tb_gfx_fetch_scheduler;

  localparam int AW = 24;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_pix;
  logic            hbl, vbl;
  logic [3:0]      req;
  logic [4*AW-1:0] req_addr;
  logic [3:0]      ack;
  logic [DW-1:0]   rd_data;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack;
  logic [DW-1:0]   mem_data;
  logic            line_sel, line_start, frame_start, spr_overrun;

  logic [AW-1:0] addr_tab [4];

  int n_checks = 0;
  int n_errors = 0;
  int ls_cnt   = 0;
  int fs_cnt   = 0;

  gfx_fetch_scheduler #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_pix     (clk_pix),
    .hbl         (hbl),
    .vbl         (vbl),
    .req         (req),
    .req_addr    (req_addr),
    .ack         (ack),
    .rd_data     (rd_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .line_sel    (line_sel),
    .line_start  (line_start),
    .frame_start (frame_start),
    .spr_overrun (spr_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk("grant_wait", 32'(mem_req), 32'd1);
  endtask

  // One full transaction: mem_ack two cycles after mem_req rises.
  task automatic serve(input logic [1:0] w, input logic [31:0] d);
    wait_grant();
    chk("mem_addr", 32'(mem_addr), 32'(addr_tab[w]));
    tick();
    tick();
    mem_ack  = 1'b1;
    mem_data = d;
    tick();
    mem_ack = 1'b0;
    chk("ack", 32'(ack), 32'(4'b0001 << w));
    chk("rd_data", rd_data, d);
    chk("done_mem_req", 32'(mem_req), 32'd0);
  endtask

  // One pixel: clk_pix high for one clk, then low for one clk.
  task automatic pix(input logic h, input logic v);
    hbl     = h;
    vbl     = v;
    clk_pix = 1'b1;
    tick();
    clk_pix = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (line_start) begin
        ls_cnt++;
        chk("line_sel", 32'(line_sel), 32'(ls_cnt % 2));
      end
      if (frame_start) fs_cnt++;
      if (s == 0) tick();
    end
  endtask

  initial begin
    addr_tab[0] = 24'hA00010;
    addr_tab[1] = 24'hA00011;
    addr_tab[2] = 24'hA00012;
    addr_tab[3] = 24'hA00013;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    reset    = 1'b1;
    clk_pix  = 1'b0;
    hbl      = 1'b0;
    vbl      = 1'b0;
    req      = 4'b1111;
    mem_ack  = 1'b0;
    mem_data = '0;

    // Reset held with all requests pending
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_line_sel", 32'(line_sel), 32'd0);
    end
    reset = 1'b0;

    // First grant after reset goes to requester 0; then reset mid-BUSY
    wait_grant();
    chk("first_grant_addr", 32'(mem_addr), 32'(addr_tab[0]));
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    mem_ack  = 1'b1;
    mem_data = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack", 32'(ack), 32'd0);
    chk("late_rd_data", rd_data, 32'd0);
    tick();
    chk("late_ack2", 32'(ack), 32'd0);
    chk("late_mem_req", 32'(mem_req), 32'd0);

    // Round robin over requesters 0..2
    req = 4'b0111;
    serve(2'd0, 32'hA5A50001);
    serve(2'd1, 32'hA5A50002);
    serve(2'd2, 32'hA5A50003);
    serve(2'd0, 32'hA5A50004);
    req = 4'b0000;

    // Sprite priority in hblank (pointer now at 1), then plain round robin
    hbl = 1'b1;
    req = 4'b1010;
    serve(2'd3, 32'hA5A50005);
    hbl = 1'b0;
    serve(2'd1, 32'hA5A50006);
    req = 4'b0000;
    tick();
    tick();

    // Six 387-pixel lines, hblank from pixel 351, vblank over lines 4-5
    for (int ln = 0; ln < 6; ln++) begin
      for (int p = 0; p < 387; p++) pix(p >= 351, ln >= 4);
    end
    chk("line_start_cnt", 32'(ls_cnt), 32'd6);
    chk("frame_start_cnt", 32'(fs_cnt), 32'd1);
    chk("line_sel_end", 32'(line_sel), 32'd0);
    chk("ovr_idle", 32'(spr_overrun), 32'd0);

    // Sprite overrun: req[3] never acknowledged across hblank end
    pix(1'b0, 1'b0);
    req = 4'b1000;
    pix(1'b1, 1'b0);
    pix(1'b1, 1'b0);
    chk("ovr_before_fall", 32'(spr_overrun), 32'd0);
    pix(1'b0, 1'b0);
    chk("ovr_set", 32'(spr_overrun), 32'd1);
    pix(1'b0, 1'b0);
    pix(1'b1, 1'b0);
    pix(1'b0, 1'b0);
    pix(1'b0, 1'b0);
    chk("ovr_hold", 32'(spr_overrun), 32'd1);
    pix(1'b0, 1'b1);
    chk("ovr_clear", 32'(spr_overrun), 32'd0);
    pix(1'b0, 1'b0);
    pix(1'b1, 1'b0);
    pix(1'b0, 1'b1);
    chk("ovr_set_wins", 32'(spr_overrun), 32'd1);
    chk("frame_start_cnt2", 32'(fs_cnt), 32'd3);
    chk("line_start_cnt2", 32'(ls_cnt), 32'd9);
    chk("no_abort", 32'(mem_req), 32'd1);
    chk("no_abort_addr", 32'(mem_addr), 32'(addr_tab[3]));

    // Final reset clears the stuck transaction and the flag
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    chk("final_mem_req", 32'(mem_req), 32'd0);
    chk("final_ovr", 32'(spr_overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
